// File: rtl/mult_hilo_unit_if.sv
// Request/result bundle between the execute stage and the HI/LO multiplier.
// The master drives operands and MT writes. The slave returns status and HI/LO.
interface mult_hilo_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, hi_we, lo_we, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_hilo_unit.sv
// Shift-add 32x32 MULT/MULTU unit that owns the HI/LO registers. Each RUN cycle retires one multiplier bit.
// Optional MULT_ZERO_SKIP_EN: a zero operand goes straight to FIX.
module mult_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  mult_hilo_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplr;
  logic               neg;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  // Magnitude is returned unsigned, so -2^31 maps to 0x80000000 without overflow.
  function automatic logic [WIDTH-1:0] mag_of(input logic signed [WIDTH-1:0] v,
                                              input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic n);
    return n ? (~p + (2*WIDTH)'(1)) : p;
  endfunction

  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH-1:0]   pp;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product;

  assign mag_a_in = mag_of(bus.op_a, bus.is_signed);
  assign mag_b_in = mag_of(bus.op_b, bus.is_signed);
  assign pp       = mag_a & {WIDTH{mplr[0]}};
  assign sum      = {1'b0, acc} + {1'b0, pp};
  assign product  = apply_sign({acc, mplr}, neg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mag_a  <= '0;
      acc    <= '0;
      mplr   <= '0;
      neg    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_r <= bus.wr_data;
          if (bus.lo_we) lo_r <= bus.wr_data;
          if (bus.start) begin
            mag_a  <= mag_a_in;
            neg    <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
            if ((mag_a_in == '0) || (mag_b_in == '0)) begin
              mplr  <= '0;
              state <= FIX;
            end else begin
              mplr  <= mag_b_in;
              state <= RUN;
            end
`else
            mplr   <= mag_b_in;
            state  <= RUN;
`endif
          end
        end
        RUN: begin
          // Add the partial product, then shift the 65-bit {carry,acc,mplr} right by one.
          acc  <= sum[WIDTH:1];
          mplr <= {sum[0], mplr[WIDTH-1:1]};
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
        end
        FIX: begin
          hi_r   <= product[2*WIDTH-1:WIDTH];
          lo_r   <= product[WIDTH-1:0];
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Scoreboard bench for mult_hilo_unit. Expected products are queued at issue and popped when done pulses.
module tb_mult_hilo_unit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  logic [63:0] sb_q[$];

  // Number of edges after the start edge at which done is first seen high.
  localparam int LAT = 33;
`ifdef MULT_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  mult_hilo_unit_if #(.WIDTH(32)) bus ();

  mult_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // kind: 0 none, 1 stray start 3x3, 2 lo_we during RUN, 3 hi_we+lo_we sampled at the FIX edge
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input int exp_lat, input int inj, input int kind);
    logic [63:0] e;
    logic [63:0] got;
    logic [31:0] lo_before;
    int cnt;
    int bcnt;
    logic seen;
    if (sg) e = 64'(longint'($signed(a)) * longint'($signed(b)));
    else    e = {32'b0, a} * {32'b0, b};
    sb_q.push_back(e);
    lo_before = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = sg; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cnt = 0; bcnt = 0; seen = 1'b0;
    while (cnt < 100 && !seen) begin
      if (bus.busy) bcnt++;
      if (cnt == inj && kind == 1) begin
        bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd3;
      end
      if (cnt == inj && kind == 2) begin
        lo_before = bus.lo; bus.lo_we = 1'b1; bus.wr_data = 32'h1;
      end
      if (cnt == inj && kind == 3) begin
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'h5A5A5A5A;
      end
      @(posedge clk); #1;
      cnt++;
      bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      if (kind == 2 && cnt == inj + 1) check("mt_ignored_busy", {32'b0, bus.lo}, {32'b0, lo_before});
      if (bus.done) begin
        seen = 1'b1;
        check("busy_low_at_done", {63'b0, bus.busy}, 64'd0);
      end
    end
    check("done_seen", {63'b0, seen}, 64'd1);
    check("done_latency", 64'(cnt), 64'(exp_lat));
    check("busy_cycles", 64'(bcnt), 64'(exp_lat));
    if (sb_q.size() != 0) begin
      got = {bus.hi, bus.lo};
      check("product", got, sb_q.pop_front());
    end
    @(posedge clk); #1;
    check("done_one_cycle", {63'b0, bus.done}, 64'd0);
  endtask

  initial begin
    int dcount;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, LAT, 0, 0);
    check("multu_max_const", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
    do_mult(32'hFFFFFFFF, 32'h00000001, 1'b1, LAT, 0, 0);
    do_mult(32'h80000000, 32'h80000000, 1'b1, LAT, 0, 0);
    check("mult_min_const", {bus.hi, bus.lo}, 64'h40000000_00000000);
    do_mult(32'h80000000, 32'h00000002, 1'b0, LAT, 0, 0);
    do_mult(32'hFFFFFFF9, 32'h00000013, 1'b1, LAT, 0, 0);
    do_mult(32'h12345678, 32'h9ABCDEF0, 1'b0, LAT, 0, 0);

    // Stray start during RUN must be dropped and produce no second done.
    do_mult(32'd7, 32'd6, 1'b0, LAT, 5, 1);
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    check("no_second_done", 64'(dcount), 64'd0);

    // MT writes in IDLE.
    @(negedge clk); bus.hi_we = 1'b1; bus.wr_data = 32'hDEADBEEF;
    @(posedge clk); #1; bus.hi_we = 1'b0;
    check("mthi_idle", {32'b0, bus.hi}, {32'b0, 32'hDEADBEEF});
    @(negedge clk); bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hCAFE0001;
    @(posedge clk); #1; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("mthilo_idle", {bus.hi, bus.lo}, 64'hCAFE0001_CAFE0001);

    do_mult(32'd1234, 32'd5678, 1'b0, LAT, 7, 2);
    do_mult(32'h0000FFFF, 32'hFFFF0000, 1'b1, LAT, 32, 3);

    // Reset mid-multiply aborts with no done and clears HI/LO.
    @(negedge clk);
    bus.start = 1'b1; bus.is_signed = 1'b0; bus.op_a = 32'h12345678; bus.op_b = 32'h9ABCDEF0;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {63'b0, bus.busy}, 64'd0);
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) dcount++;
    end
    check("abort_no_done", 64'(dcount), 64'd0);
    do_mult(32'd5, 32'd5, 1'b0, LAT, 0, 0);
    check("post_reset_25", {bus.hi, bus.lo}, 64'd25);

    do_mult(32'd0, 32'h00001234, 1'b0, ZLAT, 0, 0);
    do_mult(32'hFFFFFFFF, 32'd0, 1'b1, ZLAT, 0, 0);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_hilo_unit.md
Name: mult_hilo_unit

Overview:
- Iterative 32x32 multiplier with HI/LO result registers for the MIPS execute stage; executes MULT and MULTU.
- Each iteration forms a partial product as the 32-bit bitwise AND of multiplicand magnitude and the replicated current multiplier bit, then adds it into a running accumulator.
- Sits beside the ALU. Its HI/LO outputs are read by MFHI/MFLO through the writeback mux. MTHI/MTLO writes come from the register-file read port.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Only 32 is verified.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- op_a  input  32  multiplicand (rs); sampled with start
- op_b  input  32  multiplier (rt); sampled with start
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wr_data  input  32  MTHI/MTLO data
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse when HI/LO take a new product
- hi  output  32  upper 32 product bits
- lo  output  32  lower 32 product bits

Behaviour:
- Reset: rst_n sampled low at a clock edge forces state IDLE. Same edge clears busy=0, done=0, hi=0, lo=0, counter=0 and all internal registers. Reset aborts any multiply in progress with no partial write to HI/LO.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1 at edge E0:
  - Latch mag_a=|op_a| and mag_b=|op_b| when is_signed=1; otherwise latch raw values.
  - Latch neg = is_signed & (op_a[31]^op_b[31]).
  - Clear the 64-bit product register {acc, mplr}, with mplr=mag_b. Clear counter. Go to RUN. busy=1 from the cycle after E0.
- Signed -2^31: magnitude 0x80000000 is held unsigned; no overflow.
- RUN, each edge:
  - pp = mag_a AND {32{mplr[0]}}.
  - sum = {1'b0,acc} + {1'b0,pp} (33 bits).
  - {acc,mplr} <= {sum,mplr[31:1]}, i.e. 65-bit value shifted right 1 and truncated to 64.
  - counter+1. After the 32nd RUN edge (E32) go to FIX.
- FIX, edge E33:
  - Product P = {acc,mplr}; if neg, P = ~P + 1 (64-bit).
  - hi<=P[63:32], lo<=P[31:0]. done<=1 for exactly the following cycle. busy<=0. State IDLE.
- Latency: start edge to done-high cycle is 34 clocks. A new start may be sampled in the done cycle, giving back-to-back issue every 34 cycles.
- start while busy=1: ignored; no queuing.
- hi_we/lo_we in IDLE: hi or lo <= wr_data at that edge. Both may be asserted together.
- start together with hi_we/lo_we in IDLE: the write takes effect; the multiply still launches and later overwrites HI/LO.
- hi_we/lo_we while busy=1, including the FIX edge: ignored. The product always wins.
- hi/lo hold their value at all times except at the FIX edge, MT writes and reset.
- done is never asserted while busy=1.

Optional Feature:
- Macro MULT_ZERO_SKIP_EN.
- Defined:
  - In IDLE with start=1, if mag_a==0 or mag_b==0, go directly to FIX with the product register cleared. FIX writes hi=0, lo=0.
  - done is high in the 2nd cycle after E0; busy is high for 1 cycle. Nonzero operands are unaffected (34-cycle latency).
- Undefined: all multiplies take 34 cycles, including zero operands.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. done high exactly 34 cycles after the start edge, for one cycle. busy high for the 33 cycles before it.
- MULT 0xFFFFFFFF x 0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0. MULTU 0x80000000 x 2 -> hi=1, lo=0.
- Start 7x6 unsigned, then pulse start with 3x3 at cycle 5 -> the second start is ignored. Result hi=0, lo=42 at cycle 34; no second done.
- Start 0x12345678 x 0x9ABCDEF0, assert rst_n=0 at cycle 10 -> busy=0, hi=lo=0, done never pulses. A new MULTU 5x5 after release gives lo=25 after 34 cycles.
- IDLE hi_we=1, wr_data=0xDEADBEEF -> hi=0xDEADBEEF next cycle. During busy, lo_we=1 with 0x1 -> lo unchanged until the FIX edge writes the product.
- MULTU 0 x 0x1234 -> hi=lo=0. done at 2 cycles with MULT_ZERO_SKIP_EN defined, 34 cycles without it.
